// File: rtl/neuron_pkg.sv
// Shared constants and state encoding for the neuron weight ROM, its reader
// and the neuron output stage.
package neuron_pkg;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int ROM_DEPTH = 128;
    localparam int CNT_W     = 8;
    localparam int ACC_W     = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/neuron_mac_acc.sv
// Unsigned multiply-accumulate register; clear wins over enable.
module neuron_mac_acc #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);
    import neuron_pkg::*;

    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    r_acc;

    assign w_prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= '0;
        else if (clr)
            r_acc <= '0;
        else if (en)
            r_acc <= r_acc + ACC_W'(w_prod);
    end

    assign acc = r_acc;
endmodule

// File: rtl/neuron_weight_reader.sv
// Walks a run of weight ROM addresses, pairs each weight with one streamed
// activation and presents the unsigned dot product with a one-cycle done.
module neuron_weight_reader #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int ROM_DEPTH = 128,
    parameter int CNT_W     = 8,
    parameter int ACC_W     = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    input  logic [DATA_W-1:0] x_data,
    input  logic              x_valid,
    output logic              x_ready,
    output logic [ACC_W-1:0]  result,
    output logic              done,
    output logic              err
);
    import neuron_pkg::*;

    localparam int SUM_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_count, r_idx;
    logic [ACC_W-1:0]    r_result;
    logic                r_err;

    logic [SUM_W-1:0]    w_end;
    logic                w_range_bad;
    logic                w_accept, w_zero, w_reject;
    logic                w_run, w_beat, w_last;
    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_acc, w_final;

    // Widened so base+count cannot wrap before the depth compare.
    assign w_end       = SUM_W'(base_addr) + SUM_W'(count);
    assign w_range_bad = w_end > SUM_W'(ROM_DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_zero   = 1'b0;
        w_reject = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        w_zero = 1'b1;
                        w_next = DONE;
                    end else if (w_range_bad) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = RUN;
                    end
                end
            end
            RUN:     if (w_beat && w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_run    = (r_state == RUN);
    assign w_beat   = w_run && x_valid;
    assign w_last   = (r_idx == r_count - CNT_W'(1));

    assign rom_en   = w_run;
    assign x_ready  = w_run;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign rom_addr = w_run ? (r_base + ADDR_W'(r_idx)) : '0;
    assign result   = r_result;
    assign err      = r_err;

    neuron_mac_acc #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (w_accept || w_zero),
        .en  (w_beat),
        .a   (rom_data),
        .b   (x_data),
        .acc (w_acc)
    );

    // Final sum must land in result on the last beat itself, ahead of the
    // accumulator register, so done sees it in the very next cycle.
    assign w_prod  = (2*DATA_W)'(rom_data) * (2*DATA_W)'(x_data);
    assign w_final = w_acc + ACC_W'(w_prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base   <= '0;
            r_count  <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_base  <= base_addr;
                r_count <= count;
                r_idx   <= '0;
            end else if (w_beat) begin
                r_idx <= r_idx + CNT_W'(1);
            end
            if (w_zero)
                r_result <= '0;
            else if (w_beat && w_last)
                r_result <= w_final;
        end
    end
endmodule

// File: tb/tb_neuron_weight_reader.sv
// Directed bench with a result scoreboard drained by an output monitor.
module tb_neuron_weight_reader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  count;
    logic        busy;
    logic [7:0]  rom_addr;
    logic        rom_en;
    logic [7:0]  rom_data;
    logic [7:0]  x_data;
    logic        x_valid;
    logic        x_ready;
    logic [23:0] result;
    logic        done;
    logic        err;

    typedef struct packed {
        logic        is_err;
        logic [23:0] res;
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] rom [0:255];

    always #5 clk = ~clk;

    // Disabled ROM drives junk so any sampling with rom_en=0 corrupts sums.
    assign rom_data = rom_en ? rom[rom_addr] : 8'hA5;

    neuron_weight_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .rom_addr  (rom_addr),
        .rom_en    (rom_en),
        .rom_data  (rom_data),
        .x_data    (x_data),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .result    (result),
        .done      (done),
        .err       (err)
    );

    always @(posedge clk) begin
        if (!rst && x_valid && x_ready)
            assert (rom_en) else $error("rom_data sampled with rom_en=0");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            exp_t e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: done=%0d err=%0d result=%0d with nothing expected",
                         done, err, result);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err !== err || e.is_err === done || e.res !== result) begin
                    fails++;
                    $display("FAIL sb_compare: got err=%0d done=%0d result=%0d expected err=%0d result=%0d",
                             err, done, result, e.is_err, e.res);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // xconst=0 streams x=1,2,3..; otherwise streams xconst every beat.
    task automatic do_job(input logic [7:0] base, input logic [7:0] cnt,
                          input int stall_at, input int stall_n, input int glitch_at,
                          input logic [7:0] xconst, input logic [23:0] exp);
        exp_q.push_back('{is_err: 1'b0, res: exp});
        base_addr = base;
        count     = cnt;
        start     = 1'b1;
        x_valid   = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < int'(cnt); k++) begin
            if (k == stall_at) begin
                x_valid = 1'b0;
                repeat (stall_n) begin
                    chk("stall_addr", rom_addr, base + k);
                    chk("stall_no_done", done, 0);
                    tick();
                end
            end
            chk("beat_addr", rom_addr, base + k);
            chk("beat_ready", x_ready, 1);
            x_data  = (xconst != 0) ? xconst : 8'(k + 1);
            x_valid = 1'b1;
            if (k == glitch_at) begin
                start     = 1'b1;
                base_addr = 8'd5;
                count     = 8'd1;
            end
            tick();
            start = 1'b0;
        end
        x_valid = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_rom_en", rom_en, 0);
        chk("done_busy", busy, 1);
        tick();
        chk("done_drop", done, 0);
        chk("busy_drop", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        x_data    = '0;
        x_valid   = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'd0;
        rom[0] = 8'd10; rom[1] = 8'd10; rom[2] = 8'd11; rom[3] = 8'd11;
        rom[126] = 8'd3; rom[127] = 8'd5;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_result", result, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // 10*1+10*2+11*3+11*4
        do_job(8'd0, 8'd4, -1, 0, -1, 8'd0, 24'd107);
        do_job(8'd0, 8'd4, 2, 3, -1, 8'd0, 24'd107);
        // 3*1 + 5*2, ends exactly at the last legal entry
        do_job(8'd126, 8'd2, -1, 0, -1, 8'd0, 24'd13);

        exp_q.push_back('{is_err: 1'b1, res: 24'd13});
        base_addr = 8'd127;
        count     = 8'd2;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("rej_err", err, 1);
        chk("rej_rom_en", rom_en, 0);
        chk("rej_busy", busy, 0);
        tick();
        chk("rej_err_drop", err, 0);
        chk("rej_result", result, 13);

        do_job(8'd9, 8'd0, -1, 0, -1, 8'd0, 24'd0);
        do_job(8'd0, 8'd4, -1, 0, 1, 8'd0, 24'd107);

        base_addr = 8'd0;
        count     = 8'd4;
        start     = 1'b1;
        tick();
        start   = 1'b0;
        x_valid = 1'b1;
        x_data  = 8'd1;
        tick();
        x_data = 8'd2;
        tick();
        x_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rom_en", rom_en, 0);
        chk("arst_rom_addr", rom_addr, 0);
        chk("arst_x_ready", x_ready, 0);
        chk("arst_result", result, 0);
        chk("arst_done", done, 0);
        tick();
        #2 rst = 1'b0;
        tick();
        do_job(8'd0, 8'd4, -1, 0, -1, 8'd0, 24'd107);

        for (int i = 0; i < 128; i++) rom[i] = 8'd255;
        do_job(8'd0, 8'd128, -1, 0, -1, 8'd255, 24'd8323200);

        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
